// File: rtl/ivbus_fifo_port_if.sv
// IV-bus strobes/data plus the TX/RX byte streams of one FIFO port.
// master: core side and stream peers; slave: the ivbus_fifo_port itself.
interface ivbus_fifo_port_if;
  logic       IO_SC;
  logic       IO_WC;
  logic       IO_n_LB_w;
  logic       IO_n_RB_w;
  logic       IO_n_LB_r;
  logic       IO_n_RB_r;
  logic [7:0] n_IV_out;
  logic [7:0] n_IV_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output IO_SC, IO_WC,
    output IO_n_LB_w, IO_n_RB_w,
    output IO_n_LB_r, IO_n_RB_r,
    output n_IV_out,
    input  n_IV_in,
    input  tx_data, tx_valid,
    output tx_ready,
    output rx_data, rx_valid,
    input  rx_ready
  );

  modport slave (
    input  IO_SC, IO_WC,
    input  IO_n_LB_w, IO_n_RB_w,
    input  IO_n_LB_r, IO_n_RB_r,
    input  n_IV_out,
    output n_IV_in,
    output tx_data, tx_valid,
    input  tx_ready,
    input  rx_data, rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/ivbus_fifo_port.sv
// IV-bus peripheral: 8-reg window (status/ctrl/counts) + byte TX/RX FIFOs.
// Ports: clk, n_reset (async low), bus (ivbus_fifo_port_if.slave).
module ivbus_fifo_port #(
  parameter bit         BANK  = 1'b0,
  parameter logic [7:0] BASE  = 8'h00,
  parameter int         DEPTH = 8
) (
  input logic        clk,
  input logic        n_reset,
  ivbus_fifo_port_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    r_addr;
  logic [1:0]    r_ctrl;
  logic          r_tx_ovf;
  logic [7:0]    r_rdq;

  logic [7:0]    r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp;
  logic [AW-1:0] r_tx_rp;
  logic [CW-1:0] r_tx_cnt;

  logic [7:0]    r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wp;
  logic [AW-1:0] r_rx_rp;
  logic [CW-1:0] r_rx_cnt;

  logic       w_wsel;
  logic       w_rsel;
  logic [7:0] w_d;
  logic       w_hit;
  logic       w_ld;
  logic       w_wr;
  logic       w_wr_rx;
  logic       w_wr_tx;
  logic       w_wr_ctl;
  logic       w_en;
  logic       w_lb;

  logic       w_tx_ne;
  logic       w_tx_full;
  logic       w_rx_ne;
  logic       w_rx_full;
  logic [7:0] w_tx_head;
  logic [7:0] w_rx_head;

  logic       w_tx_valid;
  logic       w_rx_ready;
  logic       w_mv;
  logic       w_tx_pop;
  logic       w_tx_push;
  logic       w_tx_drop;
  logic       w_rx_push;
  logic       w_rx_pop;
  logic [7:0] w_rx_din;

  logic       w_a_st;
  logic       w_a_rx;
  logic       w_a_ctl;
  logic       w_a_rc;
  logic       w_a_tc;
  logic [7:0] w_stat;
  logic [7:0] w_rd;

  assign w_wsel = BANK ? ~bus.IO_n_RB_w
                       : ~bus.IO_n_LB_w;
  assign w_rsel = BANK ? ~bus.IO_n_RB_r
                       : ~bus.IO_n_LB_r;
  assign w_d    = ~bus.n_IV_out;
  assign w_hit  = (r_addr[7:3] == BASE[7:3]);

  // Address load ignores the window match so every
  // instance tracks the current address.
  assign w_ld = w_wsel & bus.IO_SC;
  assign w_wr = w_wsel & bus.IO_WC
              & ~bus.IO_SC & w_hit;

  assign w_wr_rx  = w_wr & (r_addr[2:0] == 3'd1);
  assign w_wr_tx  = w_wr & (r_addr[2:0] == 3'd2);
  assign w_wr_ctl = w_wr & (r_addr[2:0] == 3'd3);

  assign w_en = r_ctrl[0];
  assign w_lb = r_ctrl[1];

  assign w_tx_ne   = (r_tx_cnt != '0);
  assign w_tx_full = (r_tx_cnt == FULL);
  assign w_rx_ne   = (r_rx_cnt != '0);
  assign w_rx_full = (r_rx_cnt == FULL);
  assign w_tx_head = r_tx_mem[r_tx_rp];
  assign w_rx_head = r_rx_mem[r_rx_rp];

  assign w_tx_valid = w_en & ~w_lb & w_tx_ne;
  assign w_rx_ready = w_en & ~w_lb & ~w_rx_full;
  assign w_mv       = w_en & w_lb
                    & w_tx_ne & ~w_rx_full;

  // A full TX FIFO still takes a push when the
  // same edge pops, since the slot frees up.
  assign w_tx_pop  = (w_tx_valid & bus.tx_ready)
                   | w_mv;
  assign w_tx_push = w_wr_tx
                   & (~w_tx_full | w_tx_pop);
  assign w_tx_drop = w_wr_tx & ~w_tx_push;

  assign w_rx_push = (w_rx_ready & bus.rx_valid)
                   | w_mv;
  assign w_rx_pop  = w_wr_rx & w_rx_ne;
  assign w_rx_din  = w_mv ? w_tx_head
                          : bus.rx_data;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_addr   <= '0;
      r_ctrl   <= '0;
      r_tx_ovf <= 1'b0;
    end else begin
      if (w_ld)
        r_addr <= w_d;
      if (w_wr_ctl)
        r_ctrl <= w_d[1:0];
      if (w_tx_drop)
        r_tx_ovf <= 1'b1;
      else if (w_wr_ctl && w_d[7])
        r_tx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push)
        r_tx_wp <= r_tx_wp + AW'(1);
      if (w_tx_pop)
        r_tx_rp <= r_tx_rp + AW'(1);
      r_tx_cnt <= r_tx_cnt
                + CW'(w_tx_push)
                - CW'(w_tx_pop);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push)
        r_rx_wp <= r_rx_wp + AW'(1);
      if (w_rx_pop)
        r_rx_rp <= r_rx_rp + AW'(1);
      r_rx_cnt <= r_rx_cnt
                + CW'(w_rx_push)
                - CW'(w_rx_pop);
    end
  end

  // Storage needs no reset: pointers and counts
  // gate every use of its contents.
  always_ff @(posedge clk) begin
    if (w_tx_push)
      r_tx_mem[r_tx_wp] <= w_d;
    if (w_rx_push)
      r_rx_mem[r_rx_wp] <= w_rx_din;
  end

  assign w_a_st  = (r_addr[2:0] == 3'd0);
  assign w_a_rx  = (r_addr[2:0] == 3'd1);
  assign w_a_ctl = (r_addr[2:0] == 3'd3);
  assign w_a_rc  = (r_addr[2:0] == 3'd4);
  assign w_a_tc  = (r_addr[2:0] == 3'd5);

  assign w_stat = {2'b00, r_tx_ovf, 1'b0,
                   ~w_tx_ne, w_tx_full,
                   w_rx_full, w_rx_ne};

  always_comb begin
    w_rd = 8'h00;
    unique case (1'b1)
      w_a_st:  w_rd = w_stat;
      w_a_rx:  w_rd = w_rx_ne ? w_rx_head
                              : 8'h00;
      w_a_ctl: w_rd = {6'b0, r_ctrl};
      w_a_rc:  w_rd = {{(8-CW){1'b0}},
                       r_rx_cnt};
      w_a_tc:  w_rd = {{(8-CW){1'b0}},
                       r_tx_cnt};
      default: w_rd = 8'h00;
    endcase
  end

  // Registered read data: one cycle behind the
  // address/state, which eases core bus timing.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)
      r_rdq <= 8'h00;
    else
      r_rdq <= w_rd;
  end

  assign bus.n_IV_in =
    (w_rsel & w_hit & ~bus.IO_SC & ~bus.IO_WC)
      ? ~r_rdq : 8'hFF;

  assign bus.tx_data  = w_tx_ne ? w_tx_head
                                : 8'h00;
  assign bus.tx_valid = w_tx_valid;
  assign bus.rx_ready = w_rx_ready;

endmodule

// File: tb/tb_ivbus_fifo_port.sv
// Scoreboard bench for ivbus_fifo_port (BANK=0, BASE=0x10, DEPTH=8).
// Stimulus pushes expected bus reads / TX bytes; a monitor checks them.
module tb_ivbus_fifo_port;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  ivbus_fifo_port_if bus();

  ivbus_fifo_port #(
    .BANK (1'b0),
    .BASE (8'h10),
    .DEPTH(8)
  ) dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] rd_q [$];
  string      rd_n [$];
  logic [7:0] tx_q [$];
  bit         rd_active = 1'b0;

  task automatic chk(string nm, logic [7:0] act,
                     logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%02h exp=%02h",
               nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act,
                      logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b",
               nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_active) begin
      if (rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_unexpected got=%02h",
                 bus.n_IV_in);
      end else begin
        chk(rd_n.pop_front(), bus.n_IV_in,
            rd_q.pop_front());
      end
    end
    if (n_reset && bus.tx_valid
        && bus.tx_ready) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected got=%02h",
                 bus.tx_data);
      end else begin
        chk("tx_data", bus.tx_data,
            tx_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.IO_SC     = 1'b0;
    bus.IO_WC     = 1'b0;
    bus.IO_n_LB_w = 1'b1;
    bus.IO_n_RB_w = 1'b1;
    bus.IO_n_LB_r = 1'b1;
    bus.IO_n_RB_r = 1'b1;
    bus.n_IV_out  = 8'hFF;
  endtask

  task automatic wstb(bit rb);
    if (rb) bus.IO_n_RB_w = 1'b0;
    else    bus.IO_n_LB_w = 1'b0;
  endtask

  task automatic addr_cyc(logic [7:0] a, bit rb);
    idle();
    bus.IO_SC    = 1'b1;
    wstb(rb);
    bus.n_IV_out = ~a;
    step();
    idle();
  endtask

  task automatic wr_data(logic [7:0] d, bit rb);
    idle();
    bus.IO_WC    = 1'b1;
    wstb(rb);
    bus.n_IV_out = ~d;
  endtask

  task automatic bus_wr(logic [7:0] a,
                        logic [7:0] d, bit rb);
    addr_cyc(a, rb);
    wr_data(d, rb);
    step();
    idle();
  endtask

  task automatic bus_rd_raw(string nm,
                            logic [7:0] a,
                            logic [7:0] raw,
                            bit rb);
    addr_cyc(a, rb);
    step();
    if (rb) bus.IO_n_RB_r = 1'b0;
    else    bus.IO_n_LB_r = 1'b0;
    rd_q.push_back(raw);
    rd_n.push_back(nm);
    rd_active = 1'b1;
    step();
    rd_active = 1'b0;
    idle();
  endtask

  task automatic rd(string nm, logic [7:0] a,
                    logic [7:0] v);
    bus_rd_raw(nm, a, ~v, 1'b0);
  endtask

  localparam logic [7:0] A_ST  = 8'h10;
  localparam logic [7:0] A_RX  = 8'h11;
  localparam logic [7:0] A_TX  = 8'h12;
  localparam logic [7:0] A_CTL = 8'h13;
  localparam logic [7:0] A_RC  = 8'h14;
  localparam logic [7:0] A_TC  = 8'h15;

  initial begin
    n_reset      = 1'b0;
    bus.tx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    idle();
    step();
    step();
    chk1("rst_tx_valid", bus.tx_valid, 1'b0);
    chk1("rst_rx_ready", bus.rx_ready, 1'b0);
    chk("rst_tx_data", bus.tx_data, 8'h00);
    chk("rst_n_iv_in", bus.n_IV_in, 8'hFF);
    n_reset = 1'b1;
    step();

    rd("status_rst", A_ST, 8'h08);

    // enable, two bytes out on handshakes
    bus_wr(A_CTL, 8'h01, 1'b0);
    chk1("en_rx_ready", bus.rx_ready, 1'b1);
    bus_wr(A_TX, 8'h41, 1'b0);
    bus_wr(A_TX, 8'h42, 1'b0);
    chk1("tx_valid_on", bus.tx_valid, 1'b1);
    rd("txcnt_2", A_TC, 8'h02);
    tx_q.push_back(8'h41);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    rd("txcnt_1", A_TC, 8'h01);
    tx_q.push_back(8'h42);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    rd("txcnt_0", A_TC, 8'h00);
    chk1("tx_valid_off", bus.tx_valid, 1'b0);

    // overflow: 9 writes into 8 slots
    for (int i = 0; i < 9; i++)
      bus_wr(A_TX, 8'h60 + 8'(i), 1'b0);
    rd("txcnt_full", A_TC, 8'h08);
    rd("status_ovf", A_ST, 8'h24);
    bus_wr(A_CTL, 8'h81, 1'b0);
    rd("status_clr", A_ST, 8'h04);
    rd("ctrl_rd", A_CTL, 8'h01);

    // push while full with a same-cycle pop
    addr_cyc(A_TX, 1'b0);
    wr_data(8'h68, 1'b0);
    tx_q.push_back(8'h60);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    idle();
    rd("txcnt_pp", A_TC, 8'h08);
    rd("status_pp", A_ST, 8'h04);
    for (int i = 1; i < 9; i++)
      tx_q.push_back(8'h60 + 8'(i));
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 40 && bus.tx_valid; i++)
      step();
    bus.tx_ready = 1'b0;
    chk1("tx_drained", bus.tx_valid, 1'b0);
    rd("txcnt_drain", A_TC, 8'h00);

    // RX fill until full
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.rx_data = 8'(i);
      chk1("rx_ready_fill", bus.rx_ready, 1'b1);
      step();
    end
    bus.rx_data = 8'h08;
    chk1("rx_ready_full", bus.rx_ready, 1'b0);
    step();
    step();
    bus.rx_valid = 1'b0;
    rd("status_rxfull", A_ST, 8'h0B);
    rd("rxdata_0", A_RX, 8'h00);
    bus_wr(A_RX, 8'h00, 1'b0);
    rd("rxdata_1", A_RX, 8'h01);
    rd("rxcnt_7", A_RC, 8'h07);
    chk1("rx_ready_again", bus.rx_ready, 1'b1);
    for (int i = 0; i < 7; i++)
      bus_wr(A_RX, 8'h00, 1'b0);
    rd("rxcnt_0", A_RC, 8'h00);
    rd("rxdata_empty", A_RX, 8'h00);
    bus_wr(A_RX, 8'h00, 1'b0);
    rd("rxcnt_pop_empty", A_RC, 8'h00);

    // loopback
    bus_wr(A_CTL, 8'h03, 1'b0);
    bus_wr(A_TX, 8'h5A, 1'b0);
    chk1("lb_tx_valid", bus.tx_valid, 1'b0);
    chk1("lb_rx_ready", bus.rx_ready, 1'b0);
    rd("lb_rxcnt", A_RC, 8'h01);
    rd("lb_rxdata", A_RX, 8'h5A);
    rd("lb_txcnt", A_TC, 8'h00);

    // other bank / outside window
    bus_wr(A_TX, 8'h77, 1'b1);
    bus_wr(A_CTL, 8'h00, 1'b1);
    bus_rd_raw("rb_read", A_ST, 8'hFF, 1'b1);
    rd("rb_txcnt", A_TC, 8'h00);
    rd("rb_ctrl", A_CTL, 8'h03);
    bus_wr(8'h22, 8'h99, 1'b0);
    bus_wr(8'h23, 8'h00, 1'b0);
    bus_rd_raw("miss_read", 8'h22, 8'hFF, 1'b0);
    rd("miss_txcnt", A_TC, 8'h00);
    rd("miss_ctrl", A_CTL, 8'h03);

    // disabled: FIFOs hold, stream idle
    bus_wr(A_CTL, 8'h00, 1'b0);
    bus_wr(A_TX, 8'h33, 1'b0);
    chk1("dis_tx_valid", bus.tx_valid, 1'b0);
    chk1("dis_rx_ready", bus.rx_ready, 1'b0);
    rd("dis_txcnt", A_TC, 8'h01);
    bus_wr(A_CTL, 8'h01, 1'b0);
    chk1("en_tx_valid", bus.tx_valid, 1'b1);
    chk("en_tx_head", bus.tx_data, 8'h33);
    bus_wr(A_TX, 8'h44, 1'b0);

    // async reset mid-stream
    @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    chk1("arst_tx_valid", bus.tx_valid, 1'b0);
    chk1("arst_rx_ready", bus.rx_ready, 1'b0);
    chk("arst_tx_data", bus.tx_data, 8'h00);
    step();
    n_reset = 1'b1;
    step();
    rd("post_status", A_ST, 8'h08);
    rd("post_txcnt", A_TC, 8'h00);
    rd("post_rxcnt", A_RC, 8'h00);
    rd("post_ctrl", A_CTL, 8'h00);

    for (int i = 0; i < 50
         && (rd_q.size() + tx_q.size()) != 0; i++)
      step();
    checks++;
    if ((rd_q.size() + tx_q.size()) != 0) begin
      failures++;
      $display("FAIL sb_drain left=%0d exp=0",
               rd_q.size() + tx_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
